// File: rtl/riscmakers_icache_refill_adapter.sv
// riscmakers_icache_refill_adapter: turns one icache refill request into one AR/R read burst and returns the assembled line.
// Optional perf counters are enabled by defining RISCMAKERS_IREFILL_PERF_EN.
package riscmakers_icache_refill_pkg;
   localparam int unsigned PLEN               = 56;
   localparam int unsigned ICACHE_LINE_WIDTH  = 128;
   localparam int unsigned ICACHE_SET_ASSOC   = 4;
   localparam int unsigned ICACHE_INDEX_WIDTH = 12;
   localparam int unsigned CACHE_ID_WIDTH     = 2;

   typedef enum logic [1:0] {ICACHE_INV_REQ, ICACHE_IFILL_ACK} icache_in_t;

   typedef struct packed {
      logic                                vld;
      logic                                all;
      logic [ICACHE_INDEX_WIDTH-1:0]       idx;
      logic [$clog2(ICACHE_SET_ASSOC)-1:0] way;
   } icache_inval_t;

   typedef struct packed {
      logic [$clog2(ICACHE_SET_ASSOC)-1:0] way;
      logic [PLEN-1:0]                     paddr;
      logic                                nc;
      logic [CACHE_ID_WIDTH-1:0]           tid;
   } icache_req_t;

   typedef struct packed {
      icache_in_t                     rtype;
      logic [ICACHE_LINE_WIDTH-1:0]   data;
      icache_inval_t                  inv;
      logic [CACHE_ID_WIDTH-1:0]      tid;
   } icache_rtrn_t;
endpackage

module riscmakers_icache_refill_adapter
   import riscmakers_icache_refill_pkg::*;
#(
   parameter int unsigned LINE_WIDTH = ICACHE_LINE_WIDTH,
   parameter int unsigned BUS_WIDTH  = 64,
   parameter int unsigned ADDR_WIDTH = PLEN,
   parameter int unsigned NUM_BEATS  = LINE_WIDTH / BUS_WIDTH
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  mem_data_req_i,
   output logic                  mem_data_ack_o,
   input  icache_req_t           mem_data_i,
   output logic                  mem_rtrn_vld_o,
   output icache_rtrn_t          mem_rtrn_o,
   output logic                  bus_ar_valid_o,
   input  logic                  bus_ar_ready_i,
   output logic [ADDR_WIDTH-1:0] bus_ar_addr_o,
   output logic [7:0]            bus_ar_len_o,
   input  logic                  bus_r_valid_i,
   output logic                  bus_r_ready_o,
   input  logic [BUS_WIDTH-1:0]  bus_r_data_i,
   input  logic                  bus_r_last_i
`ifdef RISCMAKERS_IREFILL_PERF_EN
   ,
   output logic [31:0]           perf_refills_o,
   output logic [31:0]           perf_busy_cycles_o
`endif
);
   localparam int unsigned CntW = $clog2(NUM_BEATS + 1);
   localparam logic [ADDR_WIDTH-1:0] NcMask   = ~ADDR_WIDTH'(7);
   localparam logic [ADDR_WIDTH-1:0] LineMask = ~ADDR_WIDTH'(LINE_WIDTH / 8 - 1);

   typedef enum logic [1:0] {IDLE, ADDR, DATA, RETURN} state_e;

   state_e                    state_q, state_d;
   logic [ADDR_WIDTH-1:0]     paddr_q, paddr_d;
   logic                      nc_q, nc_d;
   logic [CACHE_ID_WIDTH-1:0] tid_q, tid_d;
   logic [LINE_WIDTH-1:0]     line_q, line_d;
   logic [CntW-1:0]           cnt_q, cnt_d;
   logic                      unused_way;

   assign unused_way = ^mem_data_i.way;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         paddr_q <= '0;
         nc_q    <= 1'b0;
         tid_q   <= '0;
         line_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         paddr_q <= paddr_d;
         nc_q    <= nc_d;
         tid_q   <= tid_d;
         line_q  <= line_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      paddr_d = paddr_q;
      nc_d    = nc_q;
      tid_d   = tid_q;
      line_d  = line_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: if (mem_data_ack_o) begin
            state_d = ADDR;
            paddr_d = mem_data_i.paddr[ADDR_WIDTH-1:0];
            nc_d    = mem_data_i.nc;
            tid_d   = mem_data_i.tid;
            line_d  = '0;
            cnt_d   = '0;
         end
         ADDR: if (bus_ar_ready_i) state_d = DATA;
         DATA: if (bus_r_valid_i) begin
            if (nc_q) begin
               line_d  = {NUM_BEATS{bus_r_data_i}};
               state_d = RETURN;
            end else begin
               // an early last leaves the lanes above this beat at their cleared value
               line_d[cnt_q*BUS_WIDTH +: BUS_WIDTH] = bus_r_data_i;
               cnt_d = cnt_q + 1'b1;
               if (bus_r_last_i || cnt_d == CntW'(NUM_BEATS)) state_d = RETURN;
            end
         end
         RETURN: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mem_data_ack_o = rst_ni && state_q == IDLE && mem_data_req_i;
      bus_ar_valid_o = state_q == ADDR;
      bus_ar_addr_o  = bus_ar_valid_o ? paddr_q & (nc_q ? NcMask : LineMask) : '0;
      bus_ar_len_o   = bus_ar_valid_o && !nc_q ? 8'(NUM_BEATS - 1) : 8'd0;
      bus_r_ready_o  = state_q == DATA;
      mem_rtrn_vld_o = state_q == RETURN;
      mem_rtrn_o     = '0;
      if (mem_rtrn_vld_o) begin
         mem_rtrn_o.rtype = ICACHE_IFILL_ACK;
         mem_rtrn_o.data  = line_q;
         mem_rtrn_o.tid   = tid_q;
      end
   end

`ifdef RISCMAKERS_IREFILL_PERF_EN
   logic [31:0] refills_q, busy_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         refills_q <= '0;
         busy_q    <= '0;
      end else begin
         if (state_q == RETURN && refills_q != '1) refills_q <= refills_q + 1'b1;
         if (state_q != IDLE && busy_q != '1) busy_q <= busy_q + 1'b1;
      end
   end

   assign perf_refills_o     = refills_q;
   assign perf_busy_cycles_o = busy_q;
`endif
endmodule

// File: tb/tb_riscmakers_icache_refill_adapter.sv
// tb_riscmakers_icache_refill_adapter: table-driven, hand-sequenced and random refills against a line-level model.
module tb_riscmakers_icache_refill_adapter;
   import riscmakers_icache_refill_pkg::*;

   logic              clk_i = 1'b0;
   logic              rst_ni = 1'b0;
   logic              mem_data_req_i = 1'b0;
   logic              mem_data_ack_o;
   icache_req_t       mem_data_i = '0;
   logic              mem_rtrn_vld_o;
   icache_rtrn_t      mem_rtrn_o;
   logic              bus_ar_valid_o;
   logic              bus_ar_ready_i = 1'b0;
   logic [PLEN-1:0]   bus_ar_addr_o;
   logic [7:0]        bus_ar_len_o;
   logic              bus_r_valid_i = 1'b0;
   logic              bus_r_ready_o;
   logic [63:0]       bus_r_data_i = '0;
   logic              bus_r_last_i = 1'b0;
`ifdef RISCMAKERS_IREFILL_PERF_EN
   logic [31:0]       perf_refills_o, perf_busy_cycles_o;
`endif

   int errors = 0;
   int checks = 0;

   riscmakers_icache_refill_adapter dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .mem_data_req_i(mem_data_req_i), .mem_data_ack_o(mem_data_ack_o), .mem_data_i(mem_data_i),
      .mem_rtrn_vld_o(mem_rtrn_vld_o), .mem_rtrn_o(mem_rtrn_o),
      .bus_ar_valid_o(bus_ar_valid_o), .bus_ar_ready_i(bus_ar_ready_i),
      .bus_ar_addr_o(bus_ar_addr_o), .bus_ar_len_o(bus_ar_len_o),
      .bus_r_valid_i(bus_r_valid_i), .bus_r_ready_o(bus_r_ready_o),
      .bus_r_data_i(bus_r_data_i), .bus_r_last_i(bus_r_last_i)
`ifdef RISCMAKERS_IREFILL_PERF_EN
      , .perf_refills_o(perf_refills_o), .perf_busy_cycles_o(perf_busy_cycles_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [PLEN-1:0] paddr;
      logic            nc;
      logic [1:0]      tid;
      logic [63:0]     b0, b1;
      logic            early, give_last, gap, dup;
      int              stall;
      logic [PLEN-1:0] e_addr;
      logic [7:0]      e_len;
      logic [127:0]    e_data;
      int              e_cycle;
   } vec_t;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [PLEN-1:0] paddr, input logic nc, input logic [1:0] tid,
                               input logic [63:0] b0, input logic [63:0] b1, input logic early,
                               input logic give_last, input int stall, input logic gap, input logic dup);
      vec_t v;
      v = '{paddr: paddr, nc: nc, tid: tid, b0: b0, b1: b1, early: early, give_last: give_last,
            gap: gap, dup: dup, stall: stall, e_addr: '0, e_len: '0, e_data: '0, e_cycle: 0};
      return v;
   endfunction

   // Line-level reference: alignment by arithmetic, beats delivered, cycle cost of stalls and gaps.
   function automatic vec_t model(input vec_t v);
      int sent;
      sent = (v.nc || v.early) ? 1 : 2;
      v.e_addr  = v.paddr - (v.paddr % PLEN'(v.nc ? 8 : 16));
      v.e_len   = v.nc ? 8'd0 : 8'd1;
      v.e_data  = v.nc ? {v.b0, v.b0} : (v.early ? {64'h0, v.b0} : {v.b1, v.b0});
      v.e_cycle = 2 + v.stall + (v.gap ? 2 * sent - 1 : sent);
      return v;
   endfunction

   task automatic chk_zero(input string tag);
      chk({tag, "_ctl"}, {mem_data_ack_o, mem_rtrn_vld_o, bus_ar_valid_o, bus_r_ready_o}, '0);
      chk({tag, "_ar"}, {bus_ar_addr_o, bus_ar_len_o}, '0);
      chk({tag, "_rtrn"}, 128'(|mem_rtrn_o), '0);
   endtask

   task automatic do_txn(input vec_t v);
      int ar_cyc = 0, arw = 0, pcyc = -1, acks = 0, bad_ar = 0, slot = 0, bi = 0;
      int nsend;
      logic [PLEN-1:0] a0 = '0;
      logic [7:0] l0 = '0;
      icache_rtrn_t r = '0;
      nsend = v.nc ? 1 : 2;
      @(posedge clk_i); #1;
      chk("idle_no_rtrn", 128'(mem_rtrn_vld_o), 0);
      mem_data_i.way   = 2'($urandom);
      mem_data_i.paddr = v.paddr;
      mem_data_i.nc    = v.nc;
      mem_data_i.tid   = v.tid;
      mem_data_req_i   = 1'b1;
      #1 chk("ack", 128'(mem_data_ack_o), 1);
      for (int c = 1; c < 200 && pcyc < 0; c++) begin
         @(posedge clk_i); #1;
         if (mem_data_ack_o) acks++;
         if (c == 1) mem_data_req_i = v.dup;
         if (bus_ar_valid_o) begin
            if (ar_cyc == 0) begin
               a0 = bus_ar_addr_o;
               l0 = bus_ar_len_o;
            end else if (bus_ar_addr_o !== a0 || bus_ar_len_o !== l0) bad_ar++;
            ar_cyc++;
            bus_ar_ready_i = arw >= v.stall;
            arw++;
         end else bus_ar_ready_i = 1'b0;
         if (bus_r_ready_o && !(v.gap && slot % 2 == 1) && bi < nsend) begin
            bus_r_valid_i = 1'b1;
            bus_r_data_i  = bi == 0 ? v.b0 : v.b1;
            bus_r_last_i  = (v.early && bi == 0) || (v.give_last && bi == nsend - 1);
            bi++;
         end else begin
            bus_r_valid_i = 1'b0;
            bus_r_data_i  = '0;
            bus_r_last_i  = 1'b0;
         end
         if (bus_r_ready_o) slot++;
         if (mem_rtrn_vld_o) begin
            pcyc = c;
            r = mem_rtrn_o;
            mem_data_req_i = 1'b0;
         end
      end
      chk("ar_addr", a0, v.e_addr);
      chk("ar_len", l0, v.e_len);
      chk("ar_stable", bad_ar, 0);
      chk("ar_cycles", ar_cyc, v.stall + 1);
      chk("rtrn_data", r.data, v.e_data);
      chk("rtrn_tid", r.tid, v.tid);
      chk("rtrn_type", r.rtype, ICACHE_IFILL_ACK);
      chk("rtrn_inv", r.inv, 0);
      chk("rtrn_cycle", pcyc, v.e_cycle);
      chk("no_extra_ack", acks, 0);
   endtask

   vec_t tbl[6];
   vec_t v;

   initial begin
      tbl[0] = mk(56'h0000_8000_1234, 0, 2'd1, 64'hAAAA_AAAA_AAAA_AAA1, 64'hBBBB_BBBB_BBBB_BBB2, 0, 0, 0, 0, 0);
      tbl[0].e_addr = 56'h0000_8000_1230; tbl[0].e_len = 8'd1; tbl[0].e_cycle = 4;
      tbl[0].e_data = {64'hBBBB_BBBB_BBBB_BBB2, 64'hAAAA_AAAA_AAAA_AAA1};
      tbl[1] = mk(56'h0000_1000_0004, 1, 2'd2, 64'h0123_4567_89AB_CDEF, 64'h0, 0, 1, 0, 0, 0);
      tbl[1].e_addr = 56'h0000_1000_0000; tbl[1].e_len = 8'd0; tbl[1].e_cycle = 3;
      tbl[1].e_data = {64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF};
      tbl[2] = mk(56'h0000_8000_0048, 0, 2'd3, 64'hCCCC_0000_1111_2222, 64'hDDDD_3333_4444_5555, 0, 1, 5, 1, 1);
      tbl[2].e_addr = 56'h0000_8000_0040; tbl[2].e_len = 8'd1; tbl[2].e_cycle = 10;
      tbl[2].e_data = {64'hDDDD_3333_4444_5555, 64'hCCCC_0000_1111_2222};
      tbl[3] = mk(56'h0000_8000_00F8, 0, 2'd0, 64'hEEEE_EEEE_EEEE_EEEE, 64'hFFFF_0000_FFFF_0000, 1, 0, 0, 0, 0);
      tbl[3].e_addr = 56'h0000_8000_00F0; tbl[3].e_len = 8'd1; tbl[3].e_cycle = 3;
      tbl[3].e_data = {64'h0, 64'hEEEE_EEEE_EEEE_EEEE};
      tbl[4] = mk(56'hFF_FFFF_FFFF_FFFF, 0, 2'd2, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 0, 1, 0, 1, 0);
      tbl[4].e_addr = 56'hFF_FFFF_FFFF_FFF0; tbl[4].e_len = 8'd1; tbl[4].e_cycle = 5;
      tbl[4].e_data = {64'h0FED_CBA9_8765_4321, 64'h1234_5678_9ABC_DEF0};
      tbl[5] = mk(56'hFF_FFFF_FFFF_FFFF, 1, 2'd1, 64'h5A5A_A5A5_5A5A_A5A5, 64'h0, 0, 0, 2, 0, 0);
      tbl[5].e_addr = 56'hFF_FFFF_FFFF_FFF8; tbl[5].e_len = 8'd0; tbl[5].e_cycle = 5;
      tbl[5].e_data = {64'h5A5A_A5A5_5A5A_A5A5, 64'h5A5A_A5A5_5A5A_A5A5};

      mem_data_req_i = 1'b1;
      #12 chk_zero("reset");
`ifdef RISCMAKERS_IREFILL_PERF_EN
      chk("reset_perf", {perf_refills_o, perf_busy_cycles_o}, 0);
`endif
      mem_data_req_i = 1'b0;
      @(negedge clk_i) rst_ni = 1'b1;

      for (int i = 0; i < 6; i++) do_txn(tbl[i]);

      // reset in DATA after the first beat
      @(posedge clk_i); #1;
      mem_data_i.paddr = 56'h0000_8000_2000; mem_data_i.nc = 1'b0; mem_data_i.tid = 2'd3;
      mem_data_req_i = 1'b1;
      @(posedge clk_i); #1 mem_data_req_i = 1'b0; bus_ar_ready_i = 1'b1;
      @(posedge clk_i); #1 bus_ar_ready_i = 1'b0; bus_r_valid_i = 1'b1; bus_r_data_i = 64'hDEAD_BEEF_DEAD_BEEF;
      @(posedge clk_i); #1 bus_r_valid_i = 1'b0; bus_r_data_i = '0;
      chk("mid_data", 128'(bus_r_ready_o), 1);
      rst_ni = 1'b0;
      #1 chk_zero("mid_reset");
      repeat (2) @(posedge clk_i);
      #1 chk("reset_no_rtrn", 128'(mem_rtrn_vld_o), 0);
      @(negedge clk_i) rst_ni = 1'b1;
      do_txn(tbl[3]);
      do_txn(tbl[0]);

      for (int i = 0; i < 24; i++) begin
         v = mk({$urandom, $urandom}, $urandom_range(0, 3) == 0, 2'($urandom), {$urandom, $urandom},
                {$urandom, $urandom}, 0, 1'($urandom), $urandom_range(0, 3), 1'($urandom), 1'($urandom));
         v.early = !v.nc && $urandom_range(0, 3) == 0;
         do_txn(model(v));
      end

`ifdef RISCMAKERS_IREFILL_PERF_EN
      @(negedge clk_i) rst_ni = 1'b0;
      @(negedge clk_i) rst_ni = 1'b1;
      chk("perf_cleared", {perf_refills_o, perf_busy_cycles_o}, 0);
      for (int i = 0; i < 3; i++) do_txn(tbl[0]);
      @(posedge clk_i); #1;
      chk("perf_refills", perf_refills_o, 3);
      chk("perf_busy", perf_busy_cycles_o, 12);
`else
      @(posedge clk_i); #1;
`endif
      chk("final_idle", {mem_rtrn_vld_o, bus_ar_valid_o, bus_r_ready_o}, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
